// File: rtl/mod_pulse_meter_pkg.sv
// Shared types and constants for the pulse meter.
package mod_pulse_meter_pkg;

    localparam int unsigned PmCntWDefault = 20;
    localparam int unsigned PmDropW       = 8;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StMeasure,
        StHold
    } pm_state_t;

endpackage

// File: rtl/mod_sync.sv
// Multi-flop synchroniser for a single asynchronous input.
// The reset level is a port so a runtime polarity input can select it.
module mod_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_val_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; reset fills it with the reset level.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            chain <= {STAGES{rst_val_i}};
        end else begin
            chain <= {chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain[STAGES-1];

endmodule

// File: rtl/mod_pulse_meter.sv
// Measures the active duration of a pin pulse in 1 us ticks and hands the
// result over with a valid/ready handshake.
module mod_pulse_meter
    import mod_pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = PmCntWDefault,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_US      = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_1us_i,
    input  logic               pin_i,
    input  logic               pin_act_lvl_i,
    input  logic               ready_i,
    output logic [CNT_W-1:0]   meas_o,
    output logic               valid_o,
    output logic               ovf_o,
    output logic               busy_o,
    output logic [PmDropW-1:0] drop_o
);

    localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_US);
    localparam logic [CNT_W-1:0] CntMax = '1;

    pm_state_t                state;
    logic                     pin_s;
    logic                     act;
    logic                     act_q;
    logic                     rise;
    logic                     fall;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_flag;
    logic [SYNC_STAGES-1:0]   warm;

    mod_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rst_val_i (~pin_act_lvl_i),
        .d_i       (pin_i),
        .q_o       (pin_s)
    );

    assign act  = pin_s ^ ~pin_act_lvl_i;
    assign rise = act & ~act_q;
    assign fall = ~act & act_q;

    // Edge-detect delay of act, plus a marker that goes high once the
    // synchroniser holds real pin samples instead of its reset fill; without
    // it a pin active through reset would look like a fresh rise.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            act_q <= 1'b0;
            warm  <= '0;
        end else begin
            act_q <= act;
            warm  <= {warm[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Measurement FSM with registered result, handshake and drop counter.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= StIdle;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            meas_o   <= '0;
            ovf_o    <= 1'b0;
            valid_o  <= 1'b0;
            drop_o   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (warm[SYNC_STAGES-1] && !act) begin
                        state <= StArmed;
                    end
                end
                StArmed: begin
                    if (rise) begin
                        cnt      <= '0;
                        ovf_flag <= 1'b0;
                        state    <= StMeasure;
                    end
                end
                StMeasure: begin
                    if (fall) begin
                        if (cnt < MinCnt) begin
                            state <= StArmed;
                        end else begin
                            meas_o  <= cnt;
                            ovf_o   <= ovf_flag;
                            valid_o <= 1'b1;
                            state   <= StHold;
                        end
                    end else if (tick_1us_i && act) begin
                        // Saturate rather than wrap; flag the lost ticks.
                        if (cnt == CntMax) begin
                            ovf_flag <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StHold: begin
                    // A rise here, even in the handshake cycle, is never measured.
                    if (rise && (drop_o != '1)) begin
                        drop_o <= drop_o + 1'b1;
                    end
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= StArmed;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy_o = (state == StMeasure);

endmodule

// File: tb/tb_mod_pulse_meter.sv
// Directed self-checking bench for mod_pulse_meter.
module tb_mod_pulse_meter;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        pin;
    logic        lvl;
    logic        ready;

    logic [19:0] meas;
    logic        valid;
    logic        ovf;
    logic        busy;
    logic [7:0]  drop;

    logic [3:0]  meas4;
    logic        valid4;
    logic        ovf4;
    logic        busy4;
    logic [7:0]  drop4;

    int passed = 0;
    int total  = 0;

    mod_pulse_meter u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tick_1us_i    (tick),
        .pin_i         (pin),
        .pin_act_lvl_i (lvl),
        .ready_i       (ready),
        .meas_o        (meas),
        .valid_o       (valid),
        .ovf_o         (ovf),
        .busy_o        (busy),
        .drop_o        (drop)
    );

    mod_pulse_meter #(
        .CNT_W (4)
    ) u_dut4 (
        .clk_i         (clk),
        .rst_i         (rst),
        .tick_1us_i    (tick),
        .pin_i         (pin),
        .pin_act_lvl_i (lvl),
        .ready_i       (ready),
        .meas_o        (meas4),
        .valid_o       (valid4),
        .ovf_o         (ovf4),
        .busy_o        (busy4),
        .drop_o        (drop4)
    );

    // Clock period 10, posedges at 5 + 10k.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle tick every 4 clocks, seen by posedges at 15 + 40k.
    initial begin
        tick = 1'b0;
        #10;
        forever begin
            tick = 1'b1;
            #10;
            tick = 1'b0;
            #30;
        end
    end

    // Start a pulse at a fixed tick phase so the rise cycle carries no tick
    // and a pulse of n*4 clocks contains exactly n counted ticks.
    task automatic pulse_start();
        @(negedge clk);
        while (($time % 40) != 10) @(negedge clk);
        pin = lvl;
    endtask

    task automatic pulse_for(input int n);
        pulse_start();
        repeat (n * 4) @(negedge clk);
        pin = ~lvl;
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        lvl   = 1'b1;
        pin   = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (meas !== 20'd0) $display("FAIL reset_meas: got %0d want 0", meas); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (drop !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop); else passed++;
        total++; if (valid4 !== 1'b0) $display("FAIL reset_valid4: got %b want 0", valid4); else passed++;
        rst = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic();
        bit got;
        pulse_start();
        repeat (100) @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passed++;
        repeat (3900) @(negedge clk);
        pin = ~lvl;
        wait_valid(got);
        total++; if (got !== 1'b1) $display("FAIL basic_valid: got %b want 1", got); else passed++;
        total++;
        if (int'(meas) < 999 || int'(meas) > 1001)
            $display("FAIL basic_meas: got %0d want 1000+/-1", meas);
        else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL basic_ovf: got %b want 0", ovf); else passed++;
        @(negedge clk);
        total++; if (valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", valid); else passed++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_glitch();
        bit got;
        bit seen = 1'b0;
        pulse_for(1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen |= valid;
        end
        total++; if (seen !== 1'b0) $display("FAIL glitch_valid: got %b want 0", seen); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy); else passed++;
        pulse_for(50);
        wait_valid(got);
        total++; if (got !== 1'b1) $display("FAIL glitch_next_valid: got %b want 1", got); else passed++;
        total++; if (meas !== 20'd50) $display("FAIL glitch_next_meas: got %0d want 50", meas); else passed++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_ovf();
        bit got;
        pulse_for(40);
        wait_valid(got);
        total++; if (got !== 1'b1) $display("FAIL ovf_valid: got %b want 1", got); else passed++;
        total++; if (valid4 !== 1'b1) $display("FAIL ovf_valid4: got %b want 1", valid4); else passed++;
        total++; if (meas4 !== 4'd15) $display("FAIL ovf_meas4: got %0d want 15", meas4); else passed++;
        total++; if (ovf4 !== 1'b1) $display("FAIL ovf_flag4: got %b want 1", ovf4); else passed++;
        total++; if (meas !== 20'd40) $display("FAIL ovf_meas: got %0d want 40", meas); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL ovf_flag: got %b want 0", ovf); else passed++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_drops();
        bit got;
        ready = 1'b0;
        pulse_for(25);
        wait_valid(got);
        total++; if (got !== 1'b1) $display("FAIL drops_first_valid: got %b want 1", got); else passed++;
        total++; if (meas !== 20'd25) $display("FAIL drops_first_meas: got %0d want 25", meas); else passed++;
        for (int p = 0; p < 3; p++) begin
            pulse_for(10);
            repeat (8) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        total++; if (valid !== 1'b1) $display("FAIL drops_held_valid: got %b want 1", valid); else passed++;
        total++; if (meas !== 20'd25) $display("FAIL drops_held_meas: got %0d want 25", meas); else passed++;
        total++; if (drop !== 8'd3) $display("FAIL drops_count: got %0d want 3", drop); else passed++;
        ready = 1'b1;
        @(negedge clk);
        total++; if (valid !== 1'b0) $display("FAIL drops_accept: got %b want 0", valid); else passed++;
        pulse_for(30);
        wait_valid(got);
        total++; if (got !== 1'b1) $display("FAIL drops_next_valid: got %b want 1", got); else passed++;
        total++; if (meas !== 20'd30) $display("FAIL drops_next_meas: got %0d want 30", meas); else passed++;
        total++; if (drop !== 8'd3) $display("FAIL drops_kept: got %0d want 3", drop); else passed++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_active_at_reset();
        bit got;
        bit seen = 1'b0;
        lvl = 1'b1;
        pin = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            seen |= busy | valid;
        end
        pin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen |= busy | valid;
        end
        total++; if (seen !== 1'b0) $display("FAIL act_reset_no_meas: got %b want 0", seen); else passed++;
        total++; if (drop !== 8'd0) $display("FAIL act_reset_drop: got %0d want 0", drop); else passed++;
        pulse_for(15);
        wait_valid(got);
        total++; if (meas !== 20'd15) $display("FAIL act_reset_meas: got %0d want 15", meas); else passed++;
        repeat (8) @(negedge clk);
        // Active-low pin: change polarity under reset.
        lvl = 1'b0;
        pin = 1'b1;
        do_reset();
        pulse_for(20);
        wait_valid(got);
        total++; if (got !== 1'b1) $display("FAIL low_valid: got %b want 1", got); else passed++;
        total++; if (meas !== 20'd20) $display("FAIL low_meas: got %0d want 20", meas); else passed++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got;
        bit seen = 1'b0;
        pulse_start();
        repeat (1200) @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (meas !== 20'd0) $display("FAIL mid_meas: got %0d want 0", meas); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy_rst: got %b want 0", busy); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL mid_ovf: got %b want 0", ovf); else passed++;
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= valid | busy;
        end
        pin = ~lvl;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen |= valid;
        end
        total++; if (seen !== 1'b0) $display("FAIL mid_no_valid: got %b want 0", seen); else passed++;
        pulse_for(5);
        wait_valid(got);
        total++; if (meas !== 20'd5) $display("FAIL mid_recover_meas: got %0d want 5", meas); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_ovf();
        test_drops();
        test_active_at_reset();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
